// File: rtl/counter_pkg.sv
// Shared definitions for the free-running counter block.
package counter_pkg;

  // Width of the default counter instance.
  localparam int DEFAULT_WIDTH = 4;

  // Count value at the default width.
  typedef logic [DEFAULT_WIDTH-1:0] count_t;

endpackage : counter_pkg

// File: rtl/counter_next.sv
// Next-count logic: increments the current count and wraps to zero once the
// terminal count is reached. Purely combinational.
module counter_next #(
  parameter int WIDTH = counter_pkg::DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] max_count,
  output logic [WIDTH-1:0] nq
);

  // Wrap at the terminal count; otherwise add one modulo 2**WIDTH.
  always_comb begin
    nq = q + WIDTH'(1);
    if (q == max_count) begin
      nq = '0;
    end
  end

endmodule : counter_next

// File: rtl/counter_unit.sv
// Free-running counter with synchronous active-high reset. The count steps
// once per rising edge of ck and wraps to zero after MAX_COUNT. The port
// order (ck, res, q) is relied on by positional instantiations.
module counter_unit
  import counter_pkg::*;
#(
  parameter int          WIDTH     = DEFAULT_WIDTH,
  parameter int unsigned MAX_COUNT = (2**WIDTH) - 1
) (
  input  logic             ck,
  input  logic             res,
  output logic [WIDTH-1:0] q
);

  // Terminal count truncated to the counter width.
  localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MAX_COUNT);

  logic [WIDTH-1:0] nq;

  counter_next #(
    .WIDTH(WIDTH)
  ) u_next (
    .q        (q),
    .max_count(MAX_Q),
    .nq       (nq)
  );

  // Count register; reset wins over the wrap at terminal count.
  always_ff @(posedge ck) begin
    if (res) begin
      q <= '0;
    end else begin
      q <= nq;
    end
  end

endmodule : counter_unit

// File: tb/tb_counter_unit.sv
// Directed bench for counter_unit: reset, counting, wrap, run length,
// mid-count reset, stability between edges and a short-terminal instance.
module tb_counter_unit;

  logic       ck;
  logic       res;
  logic [3:0] q;
  logic [3:0] q_short;

  int pass_cnt  = 0;
  int total_cnt = 0;

  // Default instance: counts 0..F.
  counter_unit dut (
    .ck (ck),
    .res(res),
    .q  (q)
  );

  // Shortened instance: counts 0..9.
  counter_unit #(
    .WIDTH    (4),
    .MAX_COUNT(9)
  ) dut_short (
    .ck (ck),
    .res(res),
    .q  (q_short)
  );

  // Clock: 10 time-unit period, rising edges at 5, 15, 25, ...
  initial ck = 1'b0;
  always #5 ck = ~ck;

  // Advance one rising edge and settle 1 unit past it before sampling.
  task automatic step();
    @(posedge ck);
    #1;
  endtask

  task automatic test_reset();
    res = 1'b1;
    for (int e = 0; e < 3; e++) begin
      step();
      total_cnt++;
      if (q !== 4'h0) $display("FAIL reset_hold edge %0d: q=%h expected 0", e, q);
      else pass_cnt++;
    end
  endtask

  task automatic test_count();
    logic [3:0] exp_v;
    res = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step();
      exp_v = 4'(i);
      total_cnt++;
      if (q !== exp_v) $display("FAIL count step %0d: q=%h expected %h", i, q, exp_v);
      else pass_cnt++;
    end
  endtask

  task automatic test_wrap();
    // Counter sits at F on entry.
    step();
    total_cnt++;
    if (q !== 4'h0) $display("FAIL wrap_to_zero: q=%h expected 0", q);
    else pass_cnt++;
    step();
    total_cnt++;
    if (q !== 4'h1) $display("FAIL wrap_then_one: q=%h expected 1", q);
    else pass_cnt++;
  endtask

  task automatic test_run_length();
    res = 1'b1;
    step();
    res = 1'b0;
    repeat (20) step();
    total_cnt++;
    if (q !== 4'h4) $display("FAIL run_length_20: q=%h expected 4", q);
    else pass_cnt++;
  endtask

  task automatic test_mid_reset();
    res = 1'b1;
    step();
    res = 1'b0;
    repeat (9) step();
    total_cnt++;
    if (q !== 4'h9) $display("FAIL mid_reset_pre: q=%h expected 9", q);
    else pass_cnt++;
    res = 1'b1;
    step();
    total_cnt++;
    if (q !== 4'h0) $display("FAIL mid_reset_clear: q=%h expected 0", q);
    else pass_cnt++;
    res = 1'b0;
    step();
    total_cnt++;
    if (q !== 4'h1) $display("FAIL mid_reset_release: q=%h expected 1", q);
    else pass_cnt++;
  endtask

  task automatic test_timing();
    // Counter holds 1 on entry; advance to 3, then watch the low phase.
    step();
    step();
    total_cnt++;
    if (q !== 4'h3) $display("FAIL timing_value: q=%h expected 3", q);
    else pass_cnt++;
    // Toggle reset while ck is low: q must not react until the next edge.
    @(negedge ck);
    #1;
    res = 1'b1;
    total_cnt++;
    if (q !== 4'h3) $display("FAIL timing_after_fall: q=%h expected 3", q);
    else pass_cnt++;
    #3;
    total_cnt++;
    if (q !== 4'h3) $display("FAIL timing_late_low: q=%h expected 3", q);
    else pass_cnt++;
    res = 1'b0;
    step();
    total_cnt++;
    if (q !== 4'h4) $display("FAIL timing_next_edge: q=%h expected 4", q);
    else pass_cnt++;
  endtask

  task automatic test_short_wrap();
    res = 1'b1;
    step();
    res = 1'b0;
    repeat (9) step();
    total_cnt++;
    if (q_short !== 4'h9) $display("FAIL short_at_max: q=%h expected 9", q_short);
    else pass_cnt++;
    step();
    total_cnt++;
    if (q_short !== 4'h0) $display("FAIL short_wrap: q=%h expected 0", q_short);
    else pass_cnt++;
    // Over a long run the short counter never leaves 0..9.
    for (int i = 0; i < 25; i++) begin
      step();
      total_cnt++;
      if (q_short > 4'h9 || $isunknown(q_short))
        $display("FAIL short_bound step %0d: q=%h expected <= 9", i, q_short);
      else pass_cnt++;
    end
  endtask

  initial begin
    res = 1'b1;
    test_reset();
    test_count();
    test_wrap();
    test_run_length();
    test_mid_reset();
    test_timing();
    test_short_wrap();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule : tb_counter_unit
